// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 keyboard receiver: the frame-state enum, the
// scancode prefix bytes and the 10-bit key event stored in the event FIFO.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    localparam int PS2_EVENT_W = $bits(ps2_event_t);

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Event channel between the frame decoder (master) and the event FIFO
// (slave): a push port for decoded events and a first-word-fall-through head.
interface ps2_kbd_rx_if #(
    parameter int W = 10
);
    logic         push;
    logic [W-1:0] push_data;
    logic         pop;
    logic [W-1:0] head;
    logic         valid;
    logic         overflow;

    modport master (output push, push_data, pop, input head, valid, overflow);
    modport slave  (input push, push_data, pop, output head, valid, overflow);
endinterface

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO. Pointers carry one extra wrap bit so
// full and empty fall out of a pointer compare. A push into a full FIFO is
// dropped (sticky overflow) unless a pop frees the slot in the same cycle.
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    ps2_kbd_rx_if.slave  ev
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             do_wr;
    logic             do_rd;
    logic             ovf;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = ev.pop && !empty;
    assign do_wr = ev.push && (!full || do_rd);

    // Pointer update and sticky overflow on a dropped push.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (ev.push && full && !do_rd) ovf <= 1'b1;
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= ev.push_data;
    end

    assign ev.head     = mem[rd_ptr[AW-1:0]];
    assign ev.valid    = !empty;
    assign ev.overflow = ovf;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: glitch-filters ps2clk, decodes 11-bit frames,
// folds E0/F0 prefixes into flags and queues {ext,brk,code} key events.
// Optional build macro PS2_KBD_TIMEOUT_EN adds a mid-frame stall abort.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILT_LEN       = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overflow,
    output logic       parity_err,
    output logic       frame_err
);
    localparam int HALF = FILT_LEN / 2;

    logic [FILT_LEN-1:0] filt;
    logic                fall_edge;
    frame_state_e        state;
    logic [2:0]          bit_cnt;
    logic [7:0]          shreg;
    logic                par_bit;
    logic                ext_flag;
    logic                brk_flag;
    logic                push;
    ps2_event_t          push_evt;
    ps2_event_t          head_evt;
    logic                timeout_hit;
    logic                byte_good;

    ps2_kbd_rx_if #(.W(PS2_EVENT_W)) ev ();

    // Shift raw ps2clk in; newest sample in bit 0.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) filt <= '0;
        else        filt <= {filt[FILT_LEN-2:0], ps2clk};
    end

    // A falling edge needs a full half-window of highs followed by a full
    // half-window of lows, so short pulses never qualify. True for one cycle.
    assign fall_edge = (&filt[FILT_LEN-1:HALF]) & ~(|filt[HALF-1:0]);

    assign byte_good = ps2data && odd_parity_ok(shreg, par_bit);

`ifdef PS2_KBD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Measure time since the last falling edge while a frame is open.
    always_ff @(posedge clk_100MHz) begin
        if (!reset)                                          to_cnt <= '0;
        else if (state == IDLE || fall_edge || timeout_hit)  to_cnt <= '0;
        else                                                 to_cnt <= to_cnt + 1'b1;
    end

    assign timeout_hit = (state != IDLE) && !fall_edge &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // No stall abort in this build; constant 0 for any legal TIMEOUT_CYCLES.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    // Frame FSM with prefix tracking and registered push/error pulses.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            push       <= 1'b0;
            push_evt   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            push       <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (timeout_hit) begin
                state     <= IDLE;
                ext_flag  <= 1'b0;
                brk_flag  <= 1'b0;
                frame_err <= 1'b1;
            end else if (fall_edge) begin
                case (state)
                    IDLE: begin
                        if (!ps2data) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {ps2data, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= ps2data;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!odd_parity_ok(shreg, par_bit)) parity_err <= 1'b1;
                        if (!ps2data)                       frame_err  <= 1'b1;
                        if (!byte_good) begin
                            ext_flag <= 1'b0;
                            brk_flag <= 1'b0;
                        end else if (shreg == PS2_PREFIX_EXT) begin
                            ext_flag <= 1'b1;
                        end else if (shreg == PS2_PREFIX_BRK) begin
                            brk_flag <= 1'b1;
                        end else begin
                            push          <= 1'b1;
                            push_evt.ext  <= ext_flag;
                            push_evt.brk  <= brk_flag;
                            push_evt.code <= shreg;
                            ext_flag      <= 1'b0;
                            brk_flag      <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ev.push      = push;
    assign ev.push_data = push_evt;
    assign ev.pop       = key_ready & ev.valid;

    ps2_event_fifo #(
        .WIDTH (PS2_EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_100MHz),
        .reset (reset),
        .ev    (ev)
    );

    // Head fields read as zero whenever no event is present.
    assign head_evt  = ev.head;
    assign key_valid = ev.valid;
    assign key_code  = ev.valid ? head_evt.code : 8'h00;
    assign key_ext   = ev.valid & head_evt.ext;
    assign key_break = ev.valid & head_evt.brk;
    assign overflow  = ev.overflow;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: frames are bit-banged with a 40-cycle PS/2
// clock; results are checked with immediate assertions.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;
    localparam int HALF = 20;
    localparam int TO   = 300;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b0;
    logic       ps2clk     = 1'b1;
    logic       ps2data    = 1'b1;
    logic       key_ready  = 1'b0;
    logic [7:0] key_code;
    logic       key_ext, key_break, key_valid, overflow, parity_err, frame_err;

    int vectors     = 0;
    int miscompares = 0;
    int perr_cnt    = 0;
    int ferr_cnt    = 0;

    ps2_kbd_rx #(
        .FILT_LEN       (8),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .ps2clk     (ps2clk),
        .ps2data    (ps2data),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_break  (key_break),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .overflow   (overflow),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(posedge clk_100MHz) begin
        if (parity_err) perr_cnt <= perr_cnt + 1;
        if (frame_err)  ferr_cnt <= ferr_cnt + 1;
    end

    initial begin
        #700000;
        $display("FAIL watchdog: run exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2data = b;
        tick(HALF);
        ps2clk = 1'b0;
        tick(HALF);
        ps2clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad_par);
        ps2_bit(stop_bit);
        tick(HALF);
    endtask

    task automatic glitch();
        ps2clk = 1'b0;
        tick(3);
        ps2clk = 1'b1;
        tick(HALF);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] code, input logic e, input logic b);
        check({tag, "_valid"}, key_valid, 1);
        check({tag, "_code"},  key_code,  code);
        check({tag, "_ext"},   key_ext,   e);
        check({tag, "_brk"},   key_break, b);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int p0, f0;

        // Reset state
        tick(4);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 8'h00);
        check("rst_ext", key_ext, 0);
        check("rst_brk", key_break, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b1;
        tick(12);

        // 0x1C with latency: fall_edge 4 clocks after the stop fall, push next, valid after
        b = 8'h1C;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b));
        ps2data = 1'b1;
        tick(HALF);
        ps2clk = 1'b0;
        tick(5);
        check("lat_early", key_valid, 0);
        tick(1);
        check("lat_on", key_valid, 1);
        tick(HALF - 6);
        ps2clk = 1'b1;
        tick(HALF);
        pop_check("k1c", 8'h1C, 1'b0, 1'b0);
        check("k1c_empty", key_valid, 0);

        // E0 F0 75 -> one extended release event
        send_frame(8'hE0, 1'b0, 1'b1);
        check("pfx_e0_none", key_valid, 0);
        send_frame(8'hF0, 1'b0, 1'b1);
        check("pfx_f0_none", key_valid, 0);
        send_frame(8'h75, 1'b0, 1'b1);
        pop_check("k75", 8'h75, 1'b1, 1'b1);
        check("k75_empty", key_valid, 0);

        // E0 6B -> extended make; flags cleared by previous event
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h6B, 1'b0, 1'b1);
        pop_check("k6b", 8'h6B, 1'b1, 1'b0);

        // E0 then 1C with bad parity: error pulse, prefix dropped, then clean 1C
        p0 = perr_cnt;
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        check("par_pulse", perr_cnt, p0 + 1);
        check("par_no_evt", key_valid, 0);
        send_frame(8'h1C, 1'b0, 1'b1);
        pop_check("par_next", 8'h1C, 1'b0, 1'b0);

        // Bad stop bit -> frame_err, no event
        f0 = ferr_cnt;
        send_frame(8'h1C, 1'b0, 1'b0);
        ps2data = 1'b1;
        tick(HALF);
        check("stop_ferr", ferr_cnt, f0 + 1);
        check("stop_no_evt", key_valid, 0);

        // 3-clock low glitches in idle (data low) and mid-frame are ignored
        ps2data = 1'b0;
        tick(HALF);
        glitch();
        ps2data = 1'b1;
        tick(HALF);
        send_frame(8'h1C, 1'b0, 1'b1);
        pop_check("glitch_idle", 8'h1C, 1'b0, 1'b0);
        b = 8'h4D;
        p0 = perr_cnt;
        f0 = ferr_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) glitch();
            ps2_bit(b[i]);
        end
        ps2_bit(~(^b));
        ps2_bit(1'b1);
        tick(HALF);
        pop_check("glitch_mid", 8'h4D, 1'b0, 1'b0);
        check("glitch_no_err", perr_cnt + ferr_cnt, p0 + f0);

        // Overflow: five makes with no consumer, four survive in order
        send_frame(8'h16, 1'b0, 1'b1);
        send_frame(8'h1E, 1'b0, 1'b1);
        send_frame(8'h26, 1'b0, 1'b1);
        send_frame(8'h25, 1'b0, 1'b1);
        check("ovf_before", overflow, 0);
        send_frame(8'h2E, 1'b0, 1'b1);
        check("ovf_set", overflow, 1);
        pop_check("drain0", 8'h16, 1'b0, 1'b0);
        pop_check("drain1", 8'h1E, 1'b0, 1'b0);
        pop_check("drain2", 8'h26, 1'b0, 1'b0);
        pop_check("drain3", 8'h25, 1'b0, 1'b0);
        check("drain_empty", key_valid, 0);
        check("ovf_sticky", overflow, 1);

        // Reset mid-frame with a queued event: everything cleared, fresh start decodes
        send_frame(8'h1C, 1'b0, 1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset = 1'b0;
        tick(3);
        check("mrst_valid", key_valid, 0);
        check("mrst_code", key_code, 8'h00);
        check("mrst_ovf", overflow, 0);
        reset = 1'b1;
        ps2data = 1'b1;
        tick(12);
        send_frame(8'h29, 1'b0, 1'b1);
        pop_check("mrst_next", 8'h29, 1'b0, 1'b0);

        // Stalled frame after 4 data bits
        b = 8'h1C;
        f0 = ferr_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i]);
`ifdef PS2_KBD_TIMEOUT_EN
        tick(TO - 60);
        check("to_early", ferr_cnt, f0);
        for (int i = 0; i < 120 && ferr_cnt == f0; i++) @(posedge clk_100MHz);
        #1;
        check("to_ferr", ferr_cnt, f0 + 1);
        check("to_no_evt", key_valid, 0);
        ps2data = 1'b1;
        tick(HALF);
        send_frame(8'h1C, 1'b0, 1'b1);
        pop_check("to_next", 8'h1C, 1'b0, 1'b0);
`else
        tick(600);
        check("stall_no_ferr", ferr_cnt, f0);
        for (int i = 4; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b));
        ps2_bit(1'b1);
        tick(HALF);
        pop_check("stall_resume", 8'h1C, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter FILT_LEN, default 8, ps2clk glitch-filter sample count (even, 4..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of buffered key events (power of two, 2..64).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, idle clocks mid-frame before abort (1 ms at 100 MHz).
REQ-004 SHALL have port: clk_100MHz  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports: ps2clk  input  1, and ps2data  input  1; raw asynchronous PS/2 lines.
REQ-007 SHALL have port: key_code  output  8  scancode of the head FIFO event.
REQ-008 SHALL have ports: key_ext  output  1, E0-prefixed flag; and key_break  output  1, F0-prefixed (release) flag.
REQ-009 SHALL have ports: key_valid  output  1, head event present; and key_ready  input  1, consumer accepts the head event.
REQ-010 SHALL have ports: overflow  output  1, sticky event lost; parity_err  output  1, one-cycle pulse; frame_err  output  1, one-cycle pulse.

Function
REQ-011 SHALL sample ps2clk into a FILT_LEN-bit shift register; fall_edge is true when the older FILT_LEN/2 samples are all 1 and the newer FILT_LEN/2 samples are all 0.
REQ-012 SHALL use frame FSM states IDLE, DATA, PARITY and STOP, each advanced only on fall_edge.
REQ-013 In IDLE, SHALL move to DATA if ps2data=0 (start bit) and stay in IDLE otherwise.
REQ-014 In DATA, SHALL shift ps2data in LSB-first and move to PARITY after exactly 8 bits.
REQ-015 In PARITY, SHALL capture the parity bit and move to STOP.
REQ-016 In STOP, SHALL return to IDLE; the byte is good only if the stop bit is 1 and data^parity has odd parity.
REQ-017 On a bad parity bit, SHALL pulse parity_err; on a bad stop bit, SHALL pulse frame_err; in both cases the byte is discarded and the prefix flags are cleared.
REQ-018 SHALL treat a good byte of 8'hE0 as setting the ext flag, with no event.
REQ-019 SHALL treat a good byte of 8'hF0 as setting the brk flag, with no event.
REQ-020 For any other good byte, SHALL push {ext,brk,byte} into the FIFO and clear both flags in the same cycle.
REQ-021 SHALL perform the push in the clock cycle after the stop-bit fall_edge cycle.
REQ-022 SHALL raise key_valid on the clock after the push when the FIFO was empty (first-word-fall-through).
REQ-023 SHALL pop on key_valid & key_ready, presenting the next entry on the following cycle.
REQ-024 SHALL ignore key_ready while key_valid=0.
REQ-025 If a push arrives when the FIFO is full and no pop occurs that cycle, SHALL drop the new event, keep the FIFO unchanged and set overflow until reset.
REQ-026 If a push and a pop occur in the same cycle, SHALL accept both, including when the FIFO is full; occupancy is unchanged.
REQ-027 SHALL keep read and write pointers log2(FIFO_DEPTH)+1 bits wide, wrapping modulo 2*FIFO_DEPTH; full/empty SHALL be derived from pointer comparison.

Reset
REQ-028 SHALL, while reset=0 at a clk_100MHz edge, clear the filter register, FSM (to IDLE), bit counter, shift register, both prefix flags, both FIFO pointers, the timeout counter and overflow.
REQ-029 SHALL hold key_code=8'h00, key_ext=0, key_break=0, key_valid=0, parity_err=0 and frame_err=0 during reset.
REQ-030 On reset asserted mid-frame, SHALL discard any partial frame; the next frame SHALL be decoded only from a fresh start bit.

Configuration
REQ-031 With PS2_KBD_TIMEOUT_EN defined, SHALL count clocks while not in IDLE, cleared on every fall_edge; on reaching TIMEOUT_CYCLES it SHALL return to IDLE, clear the prefix flags and pulse frame_err.
REQ-032 Without PS2_KBD_TIMEOUT_EN, SHALL contain no timeout counter, so a stalled frame waits indefinitely.

Structure
REQ-033 SHALL use shared package ps2_pkg holding the frame-state enum, PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0 and the 10-bit event entry type.
REQ-034 SHALL place the FIFO in sub-module ps2_event_fifo, parametrised by width and FIFO_DEPTH.

Verification
REQ-035 Bench SHALL check: frame 0x1C, good parity -> one event {ext=0,brk=0,code=0x1C}, key_valid high 2 cycles after the stop-bit edge.
REQ-036 Bench SHALL check: frames E0, F0, 75 -> one event {ext=1,brk=1,code=0x75}; no events for the prefixes.
REQ-037 Bench SHALL check: frame 0x1C with a flipped parity bit -> parity_err pulses once, no event; a following frame 0x1C -> normal event.
REQ-038 Bench SHALL check: key_ready=0 with FIFO_DEPTH=4 and 5 make codes 0x16,0x1E,0x26,0x25,0x2E -> overflow=1; draining yields 0x16,0x1E,0x26,0x25.
REQ-039 Bench SHALL check: 3-clock-wide low glitch on ps2clk with FILT_LEN=8 -> no state change.
REQ-040 Bench SHALL check: with PS2_KBD_TIMEOUT_EN, stop ps2clk after 4 data bits -> frame_err after TIMEOUT_CYCLES clocks; the next full frame 0x1C decodes correctly.
